// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and defaults for the data-memory arbiter
// Purpose: read-return owner encoding, arbiter FSM states, default starvation threshold.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  typedef enum logic {
    PIPE_PRIO = 1'b0,
    FORCE_D   = 1'b1
  } state_t;

  localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - bus bundle between pipeline/debug requesters, arbiter and data memory
// Purpose: groups the M requester, D requester and memory-port signals.
// slave  : arbiter view (requests in, grants/read data/memory strobes out, mem_rdata in)
// master : environment view (pipeline, debug port and memory), directions mirrored
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              stall_m;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    output stall_m, m_rvalid, m_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    input  stall_m, m_rvalid, m_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/starve_counter.sv
// rtl/starve_counter.sv - saturating count of consecutive denied D cycles
// Ports: clk, rst (async, active-low), clr (D granted), inc (D denied), at_max (count == MAX).
module starve_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  logic [W-1:0] cnt;

  assign at_max = (cnt == W'(MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data-memory arbiter, pipeline priority with D starvation guard
// Ports: clk, rst (async, active-low), bus (dmem_arbiter_if.slave):
//   M: m_req/m_we/m_addr/m_wdata in, stall_m/m_rvalid/m_rdata out
//   D: d_req/d_we/d_addr/d_wdata in, d_gnt/d_rvalid/d_rdata out
//   memory: mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in (one-cycle read latency)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  dmem_arbiter_if.slave  bus
);

  state_t state, state_nxt;
  owner_t rd_owner, rd_owner_nxt;
  logic   at_max;
  logic   force_d;
  logic   d_gnt;
  logic   m_gnt;

  // Grants are gated by rst so nothing reaches memory while reset is held.
  assign force_d = at_max || (state == FORCE_D);
  assign d_gnt   = rst && bus.d_req && (!bus.m_req || force_d);
  assign m_gnt   = rst && bus.m_req && !d_gnt;

  starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .clr    (d_gnt),
    .inc    (rst && bus.d_req && !d_gnt),
    .at_max (at_max)
  );

  // FORCE_D remembers a saturated D while its request is dropped; the
  // counter also holds at max there, so the two stay consistent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= PIPE_PRIO;
      rd_owner <= OWN_NONE;
    end else begin
      state    <= state_nxt;
      rd_owner <= rd_owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PIPE_PRIO: if (at_max && !d_gnt) state_nxt = FORCE_D;
      FORCE_D:   if (d_gnt)            state_nxt = PIPE_PRIO;
      default:   state_nxt = PIPE_PRIO;
    endcase
  end

  always_comb begin
    rd_owner_nxt = OWN_NONE;
    if (d_gnt && !bus.d_we) begin
      rd_owner_nxt = OWN_D;
    end else if (m_gnt && !bus.m_we) begin
      rd_owner_nxt = OWN_M;
    end
  end

  always_comb begin
    bus.mem_en    = m_gnt || d_gnt;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    if (d_gnt) begin
      bus.mem_we    = bus.d_we;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end else if (m_gnt) begin
      bus.mem_we    = bus.m_we;
      bus.mem_addr  = bus.m_addr;
      bus.mem_wdata = bus.m_wdata;
    end
  end

  assign bus.d_gnt    = d_gnt;
  assign bus.stall_m  = bus.m_req && d_gnt;
  assign bus.m_rvalid = (rd_owner == OWN_M);
  assign bus.d_rvalid = (rd_owner == OWN_D);
  assign bus.m_rdata  = (rd_owner == OWN_M) ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.d_rdata  = (rd_owner == OWN_D) ? bus.mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with directed vectors
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  typedef struct {
    owner_t      own;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Data memory model: registered read, seeded while reset is held.
  logic [31:0] mem [16];
  logic [31:0] rdata_q = 32'h0;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[1] <= 32'hA5A5A5A5;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
      else            rdata_q <= mem[bus.mem_addr[5:2]];
    end
  end
  assign bus.mem_rdata = rdata_q;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every rvalid must match the next queued read in issue order.
  initial begin
    exp_t   e;
    owner_t act_own;
    forever begin
      @(negedge clk);
      if (bus.m_rvalid || bus.d_rvalid) begin
        chk("rvalid_exclusive", {31'b0, bus.m_rvalid & bus.d_rvalid}, 32'h0);
        act_own = bus.m_rvalid ? OWN_M : OWN_D;
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", {30'b0, act_own}, {30'b0, OWN_NONE});
        end else begin
          e = sb.pop_front();
          chk("rd_owner", {30'b0, act_own}, {30'b0, e.own});
          if (act_own == OWN_M) begin
            chk("m_rdata", bus.m_rdata, e.data);
            chk("d_rdata_idle", bus.d_rdata, 32'h0);
          end else begin
            chk("d_rdata", bus.d_rdata, e.data);
            chk("m_rdata_idle", bus.m_rdata, 32'h0);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic mr, input logic mw, input logic [31:0] ma, input logic [31:0] md,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    bus.m_req = mr; bus.m_we = mw; bus.m_addr = ma; bus.m_wdata = md;
    bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
  endtask

  // One arbitration cycle: drive, check the combinational grant, queue read returns.
  task automatic step(input string tag,
                      input logic mr, input logic mw, input logic [31:0] ma, input logic [31:0] md,
                      input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                      input logic exp_d, input logic [31:0] m_exp, input logic [31:0] d_exp,
                      input bit expect_ret);
    logic exp_m;
    exp_t e;
    @(posedge clk);
    #1;
    drive(mr, mw, ma, md, dr, dw, da, dd);
    #1;
    exp_m = mr && !exp_d;
    chk({tag, ".d_gnt"},   {31'b0, bus.d_gnt},   {31'b0, exp_d});
    chk({tag, ".stall_m"}, {31'b0, bus.stall_m}, {31'b0, mr && exp_d});
    chk({tag, ".mem_en"},  {31'b0, bus.mem_en},  {31'b0, exp_m || exp_d});
    if (exp_d) begin
      chk({tag, ".mem_addr"}, bus.mem_addr, da);
      chk({tag, ".mem_we"},   {31'b0, bus.mem_we}, {31'b0, dw});
      if (dw) chk({tag, ".mem_wdata"}, bus.mem_wdata, dd);
    end else if (exp_m) begin
      chk({tag, ".mem_addr"}, bus.mem_addr, ma);
      chk({tag, ".mem_we"},   {31'b0, bus.mem_we}, {31'b0, mw});
    end
    if (expect_ret && exp_d && !dw) begin
      e.own = OWN_D; e.data = d_exp; sb.push_back(e);
    end
    if (expect_ret && exp_m && !mw) begin
      e.own = OWN_M; e.data = m_exp; sb.push_back(e);
    end
  endtask

  initial begin
    // Reset with both requesting: nothing may be granted.
    drive(1'b1, 1'b1, 32'h10, 32'h1, 1'b1, 1'b0, 32'h8, 32'h0);
    #12;
    chk("rst.mem_en",   {31'b0, bus.mem_en},   32'h0);
    chk("rst.d_gnt",    {31'b0, bus.d_gnt},    32'h0);
    chk("rst.stall_m",  {31'b0, bus.stall_m},  32'h0);
    chk("rst.m_rvalid", {31'b0, bus.m_rvalid}, 32'h0);
    chk("rst.d_rvalid", {31'b0, bus.d_rvalid}, 32'h0);
    chk("rst.m_rdata",  bus.m_rdata, 32'h0);
    chk("rst.d_rdata",  bus.d_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("release.mem_en",   {31'b0, bus.mem_en},  32'h1);
    chk("release.d_gnt",    {31'b0, bus.d_gnt},   32'h0);
    chk("release.stall_m",  {31'b0, bus.stall_m}, 32'h0);
    chk("release.mem_addr", bus.mem_addr, 32'h10);

    step("m_read4",  1, 0, 32'h4, 0,  0, 0, 32'h0, 0,             0, 32'hA5A5A5A5, 0, 1);
    step("idle",     0, 0, 32'h0, 0,  0, 0, 32'h0, 0,             0, 0, 0, 1);
    step("d_write8", 0, 0, 32'h0, 0,  1, 1, 32'h8, 32'h12345678,  1, 0, 0, 1);
    step("m_read8",  1, 0, 32'h8, 0,  0, 0, 32'h0, 0,             0, 32'h12345678, 0, 1);

    for (int k = 0; k < 10; k++)
      step("starve", 1, 0, 32'h4, 0, 1, 0, 32'h8, 0, (k % 5) == 4, 32'hA5A5A5A5, 32'h12345678, 1);

    // Saturate, drop d_req: M still served; D forced on its return.
    for (int k = 0; k < 4; k++)
      step("sat", 1, 0, 32'h4, 0, 1, 0, 32'h8, 0, 0, 32'hA5A5A5A5, 32'h12345678, 1);
    step("force_hold0", 1, 0, 32'h4, 0, 0, 0, 32'h0, 0, 0, 32'hA5A5A5A5, 0, 1);
    step("force_hold1", 1, 0, 32'h4, 0, 0, 0, 32'h0, 0, 0, 32'hA5A5A5A5, 0, 1);
    step("force_gnt",   1, 0, 32'h4, 0, 1, 0, 32'h8, 0, 1, 32'hA5A5A5A5, 32'h12345678, 1);
    step("after_force", 1, 0, 32'h4, 0, 1, 0, 32'h8, 0, 0, 32'hA5A5A5A5, 32'h12345678, 1);

    step("alt_m", 1, 0, 32'h4, 0, 0, 0, 32'h0, 0, 0, 32'hA5A5A5A5, 0, 1);
    step("alt_d", 0, 0, 32'h0, 0, 1, 0, 32'h8, 0, 1, 0, 32'h12345678, 1);
    step("idle",  0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 1);

    // Reset mid-read: counter is non-zero beforehand, returned read must vanish.
    step("pre_rst",  1, 1, 32'h20, 32'h7, 1, 0, 32'h8, 0, 0, 0, 0, 1);
    step("rst_read", 1, 0, 32'h4,  0,     0, 0, 32'h0, 0, 0, 32'hA5A5A5A5, 0, 0);
    #2;
    rst = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    @(posedge clk);
    #1;
    chk("rst_mid.mem_en",   {31'b0, bus.mem_en},   32'h0);
    chk("rst_mid.m_rvalid", {31'b0, bus.m_rvalid}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 5; k++)
      step("post_rst", 1, 1, 32'h20, 32'h3, 1, 1, 32'h24, 32'h5, k == 4, 0, 0, 1);
    step("idle", 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 1);
    step("idle", 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("sb_empty", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the pipeline's memory stage (requester M) and a secondary debug/loader port (requester D). M has priority by default. A saturating starvation counter guarantees D forward progress by stalling the pipeline for one access once the threshold is hit. The block sits between the memory-cycle logic and the data memory, and routes one-cycle-latency read data back to whichever requester issued the read.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive denied D cycles before D is forced through (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- m_req  in  1  memory stage requests an access this cycle
- m_we  in  1  1 = write, 0 = read
- m_addr  in  ADDR_W  M address
- m_wdata  in  DATA_W  M write data
- stall_m  out  1  M request not served this cycle; pipeline holds M stage
- m_rvalid  out  1  M read data valid
- m_rdata  out  DATA_W  M read data
- d_req  in  1  D requests an access
- d_we  in  1  D write enable
- d_addr  in  ADDR_W  D address
- d_wdata  in  DATA_W  D write data
- d_gnt  out  1  D access issued this cycle
- d_rvalid  out  1  D read data valid
- d_rdata  out  DATA_W  D read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read is issued

## Operation
- Grant decision, combinational, each cycle:
  - d_gnt = d_req && (!m_req || starve_cnt == STARVE_MAX)
  - m_gnt = m_req && !d_gnt
  - stall_m = m_req && d_gnt
- Memory port: mem_en = m_gnt | d_gnt. mem_we, mem_addr and mem_wdata are muxed from the granted requester. They are 0 when nothing is granted.
- starve_cnt, width clog2(STARVE_MAX+1):
  - clears on d_gnt
  - increments on d_req && !d_gnt
  - saturates at STARVE_MAX
  - holds otherwise
- FSM, two states:
  - PIPE_PRIO: default.
  - FORCE_D: entered when starve_cnt reaches STARVE_MAX.
  - In FORCE_D the next D request is granted even if m_req=1. The FSM returns to PIPE_PRIO on that grant.
  - If d_req drops while in FORCE_D, the FSM stays in FORCE_D and the counter holds.
- Read return:
  - rd_owner register (NONE/M/D) is set on a granted read (mem_we=0) and is NONE otherwise.
  - Next cycle: m_rvalid=1 if rd_owner==M; d_rvalid=1 if rd_owner==D.
  - The owning rdata port is driven from mem_rdata. The non-owning rdata port is 0.
- Writes produce no rvalid.
- Reset (rst=0, async):
  - starve_cnt=0, FSM=PIPE_PRIO, rd_owner=NONE.
  - m_rvalid=0, d_rvalid=0, m_rdata=0, d_rdata=0.
  - While rst=0: mem_en=0, d_gnt=0, stall_m=0.
- Reset mid-operation: an in-flight read return is discarded (no rvalid after release).

## Timing
- Grant and memory strobe: same cycle as the request (zero latency).
- Read latency: rvalid and rdata one cycle after the grant cycle. Back-to-back reads from alternating owners return in issue order.
- Stall: stall_m is asserted exactly in the cycle D is granted over a pending M request. M's access is issued the following cycle if m_req is held.
- Simultaneous m_req and d_req with starve_cnt < STARVE_MAX: M wins, counter increments.
- With both requesting continuously, D is granted once every STARVE_MAX+1 cycles.
- First edge after rst deasserts: normal arbitration.

## Structure
- Package dmem_arb_pkg:
  - owner_t enum {OWN_NONE, OWN_M, OWN_D}
  - state enum {PIPE_PRIO, FORCE_D}
  - default STARVE_MAX constant
- Sub-module starve_counter: saturating counter with clr/inc inputs and an at_max output. The remainder (grant mux, FSM, return routing) lives in dmem_arbiter.

## Test plan
1. Reset: rst=0 with m_req=d_req=1 → mem_en=0, d_gnt=0, stall_m=0, rvalids 0. Release → M granted that cycle.
2. M-only read: m_req=1, m_we=0, m_addr=0x4, memory holds 0xA5A5A5A5 at 0x4 → mem_en=1 same cycle; next cycle m_rvalid=1, m_rdata=0xA5A5A5A5, d_rvalid=0.
3. D-only write: d_req=1, d_we=1, d_addr=0x8, d_wdata=0x12345678 → d_gnt=1, mem_we=1, no rvalid. A later M read of 0x8 returns 0x12345678.
4. Starvation, STARVE_MAX=4: both request every cycle → M granted 4 cycles, D granted on the 5th with stall_m=1, pattern repeats every 5 cycles.
5. Alternating reads M@0x4 then D@0x8 on consecutive cycles → m_rvalid then d_rvalid on consecutive cycles, each with the correct data, never both high.
6. Reset mid-read: grant M read, assert rst before the next edge → m_rvalid stays 0. starve_cnt=0 after release.
